// File: rtl/blimp_mem_arbiter.sv
// Round-robin merge of the Blimp instruction and data memory clients onto one
// in-order backend port; a source-ID FIFO steers each response back to its issuer.
module blimp_mem_arbiter #(
  parameter int unsigned p_opaq_bits    = 8,
  parameter int unsigned p_max_inflight = 4
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   imem_req_val,
  output logic                   imem_req_rdy,
  input  logic                   imem_req_op,
  input  logic [31:0]            imem_req_addr,
  input  logic [31:0]            imem_req_wdata,
  input  logic [p_opaq_bits-1:0] imem_req_opaque,
  output logic                   imem_resp_val,
  input  logic                   imem_resp_rdy,
  output logic                   imem_resp_op,
  output logic [31:0]            imem_resp_rdata,
  output logic [p_opaq_bits-1:0] imem_resp_opaque,

  input  logic                   dmem_req_val,
  output logic                   dmem_req_rdy,
  input  logic                   dmem_req_op,
  input  logic [31:0]            dmem_req_addr,
  input  logic [31:0]            dmem_req_wdata,
  input  logic [p_opaq_bits-1:0] dmem_req_opaque,
  output logic                   dmem_resp_val,
  input  logic                   dmem_resp_rdy,
  output logic                   dmem_resp_op,
  output logic [31:0]            dmem_resp_rdata,
  output logic [p_opaq_bits-1:0] dmem_resp_opaque,

  output logic                   be_req_val,
  input  logic                   be_req_rdy,
  output logic                   be_req_op,
  output logic [31:0]            be_req_addr,
  output logic [31:0]            be_req_wdata,
  output logic [p_opaq_bits-1:0] be_req_opaque,
  input  logic                   be_resp_val,
  output logic                   be_resp_rdy,
  input  logic                   be_resp_op,
  input  logic [31:0]            be_resp_rdata,
  input  logic [p_opaq_bits-1:0] be_resp_opaque
);

  localparam int unsigned PTR_W = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
  localparam int unsigned CNT_W = $clog2(p_max_inflight + 1);

  // Source IDs: 0 = inst client, 1 = data client
  logic [p_max_inflight-1:0] id_q, id_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      pri_q, pri_d;

  logic fifo_full, fifo_empty, any_val, win_id, can_issue;
  logic head_id, req_fire, resp_fire;

  // Arbitration and request forwarding
  always_comb begin
    fifo_full  = (count_q == CNT_W'(p_max_inflight));
    fifo_empty = (count_q == CNT_W'(0));
    any_val    = imem_req_val | dmem_req_val;
    win_id     = (imem_req_val & dmem_req_val) ? pri_q : dmem_req_val;
    can_issue  = be_req_rdy & ~fifo_full;

    be_req_val    = any_val & ~fifo_full;
    be_req_op     = win_id ? dmem_req_op     : imem_req_op;
    be_req_addr   = win_id ? dmem_req_addr   : imem_req_addr;
    be_req_wdata  = win_id ? dmem_req_wdata  : imem_req_wdata;
    be_req_opaque = win_id ? dmem_req_opaque : imem_req_opaque;

    imem_req_rdy = any_val & ~win_id & can_issue;
    dmem_req_rdy = any_val &  win_id & can_issue;
    req_fire     = be_req_val & be_req_rdy;
  end

  // Response routing from the FIFO head
  always_comb begin
    head_id     = id_q[rd_ptr_q];
    be_resp_rdy = ~fifo_empty & (head_id ? dmem_resp_rdy : imem_resp_rdy);
    resp_fire   = be_resp_val & be_resp_rdy;

    imem_resp_val    = be_resp_val & ~fifo_empty & ~head_id;
    dmem_resp_val    = be_resp_val & ~fifo_empty &  head_id;
    imem_resp_op     = be_resp_op;
    dmem_resp_op     = be_resp_op;
    imem_resp_rdata  = be_resp_rdata;
    dmem_resp_rdata  = be_resp_rdata;
    imem_resp_opaque = be_resp_opaque;
    dmem_resp_opaque = be_resp_opaque;
  end

  // FIFO and priority next state; a full FIFO never accepts a same-cycle push
  always_comb begin
    id_d     = id_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pri_d    = pri_q;

    if (req_fire) begin
      id_d[wr_ptr_q] = win_id;
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
      pri_d          = ~win_id;
    end
    if (resp_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (req_fire && !resp_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!req_fire && resp_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pri_q    <= 1'b0;
    end else begin
      id_q     <= id_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pri_q    <= pri_d;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding means the backend broke protocol
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(be_resp_val && fifo_empty))
        else $error("blimp_mem_arbiter: backend response with no outstanding request");
    end
  end

  function automatic string trace();
    string g;
    g = req_fire ? (win_id ? "D" : "I") : ".";
    return $sformatf("%s cnt=%0d", g, count_q);
  endfunction
`endif

endmodule

// File: tb/tb_blimp_mem_arbiter.sv
// Directed bench for blimp_mem_arbiter: single client, round-robin, full FIFO,
// back-pressure, wrap ordering and mid-flight reset.
module tb_blimp_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_val, imem_req_rdy, imem_req_op;
  logic [31:0] imem_req_addr, imem_req_wdata;
  logic [7:0]  imem_req_opaque;
  logic        imem_resp_val, imem_resp_rdy, imem_resp_op;
  logic [31:0] imem_resp_rdata;
  logic [7:0]  imem_resp_opaque;
  logic        dmem_req_val, dmem_req_rdy, dmem_req_op;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]  dmem_req_opaque;
  logic        dmem_resp_val, dmem_resp_rdy, dmem_resp_op;
  logic [31:0] dmem_resp_rdata;
  logic [7:0]  dmem_resp_opaque;
  logic        be_req_val, be_req_rdy, be_req_op;
  logic [31:0] be_req_addr, be_req_wdata;
  logic [7:0]  be_req_opaque;
  logic        be_resp_val, be_resp_rdy, be_resp_op;
  logic [31:0] be_resp_rdata;
  logic [7:0]  be_resp_opaque;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  blimp_mem_arbiter #(.p_opaq_bits(8), .p_max_inflight(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_val(imem_req_val), .imem_req_rdy(imem_req_rdy), .imem_req_op(imem_req_op),
    .imem_req_addr(imem_req_addr), .imem_req_wdata(imem_req_wdata),
    .imem_req_opaque(imem_req_opaque),
    .imem_resp_val(imem_resp_val), .imem_resp_rdy(imem_resp_rdy), .imem_resp_op(imem_resp_op),
    .imem_resp_rdata(imem_resp_rdata), .imem_resp_opaque(imem_resp_opaque),
    .dmem_req_val(dmem_req_val), .dmem_req_rdy(dmem_req_rdy), .dmem_req_op(dmem_req_op),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
    .dmem_req_opaque(dmem_req_opaque),
    .dmem_resp_val(dmem_resp_val), .dmem_resp_rdy(dmem_resp_rdy), .dmem_resp_op(dmem_resp_op),
    .dmem_resp_rdata(dmem_resp_rdata), .dmem_resp_opaque(dmem_resp_opaque),
    .be_req_val(be_req_val), .be_req_rdy(be_req_rdy), .be_req_op(be_req_op),
    .be_req_addr(be_req_addr), .be_req_wdata(be_req_wdata), .be_req_opaque(be_req_opaque),
    .be_resp_val(be_resp_val), .be_resp_rdy(be_resp_rdy), .be_resp_op(be_resp_op),
    .be_resp_rdata(be_resp_rdata), .be_resp_opaque(be_resp_opaque)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    imem_req_val = 1'b0; imem_req_op = 1'b0; imem_req_addr = 32'h1000;
    imem_req_wdata = 32'h0; imem_req_opaque = 8'h00; imem_resp_rdy = 1'b0;
    dmem_req_val = 1'b0; dmem_req_op = 1'b1; dmem_req_addr = 32'h2000;
    dmem_req_wdata = 32'h55; dmem_req_opaque = 8'h00; dmem_resp_rdy = 1'b0;
    be_req_rdy = 1'b0; be_resp_val = 1'b0; be_resp_op = 1'b0;
    be_resp_rdata = 32'h0; be_resp_opaque = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int seq [6] = '{0, 1, 1, 0, 1, 0};
  int dcnt;

  initial begin
    idle_all();
    do_reset();

    // Reset state: everything quiet even with backend ready
    be_req_rdy = 1'b1; imem_resp_rdy = 1'b1; dmem_resp_rdy = 1'b1;
    #1;
    check("rst_be_req_val", 32'(be_req_val), 32'd0);
    check("rst_imem_req_rdy", 32'(imem_req_rdy), 32'd0);
    check("rst_dmem_req_rdy", 32'(dmem_req_rdy), 32'd0);
    check("rst_be_resp_rdy", 32'(be_resp_rdy), 32'd0);
    check("rst_count", 32'(dut.count_q), 32'd0);

    // Single inst read, response three cycles later
    idle_all();
    be_req_rdy = 1'b1;
    imem_req_val = 1'b1; imem_req_addr = 32'h200; imem_req_opaque = 8'h11;
    #1;
    check("t1_be_req_val", 32'(be_req_val), 32'd1);
    check("t1_be_req_addr", be_req_addr, 32'h200);
    check("t1_be_req_opaque", 32'(be_req_opaque), 32'h11);
    check("t1_imem_req_rdy", 32'(imem_req_rdy), 32'd1);
    check("t1_dmem_req_rdy", 32'(dmem_req_rdy), 32'd0);
    tick();
    imem_req_val = 1'b0;
    tick();
    tick();
    be_resp_val = 1'b1; be_resp_rdata = 32'hDEADBEEF; be_resp_opaque = 8'h11;
    imem_resp_rdy = 1'b1; dmem_resp_rdy = 1'b1;
    #1;
    check("t1_imem_resp_val", 32'(imem_resp_val), 32'd1);
    check("t1_imem_resp_rdata", imem_resp_rdata, 32'hDEADBEEF);
    check("t1_imem_resp_opaque", 32'(imem_resp_opaque), 32'h11);
    check("t1_dmem_resp_val", 32'(dmem_resp_val), 32'd0);
    check("t1_be_resp_rdy", 32'(be_resp_rdy), 32'd1);
    tick();
    be_resp_val = 1'b0;
    #1;
    check("t1_count_after", 32'(dut.count_q), 32'd0);

    // Both clients every cycle, 1-cycle backend: grants alternate from inst
    idle_all();
    do_reset();
    be_req_rdy = 1'b1; imem_resp_rdy = 1'b1; dmem_resp_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_req_val = (i < 4);
      dmem_req_val = (i < 4);
      be_resp_val  = (i > 0);
      be_resp_rdata = 32'hA000_0000 + 32'(i);
      #1;
      if (i < 4) begin
        check("rr_grant_addr", be_req_addr, ((i % 2) == 0) ? 32'h1000 : 32'h2000);
        check("rr_imem_req_rdy", 32'(imem_req_rdy), ((i % 2) == 0) ? 32'd1 : 32'd0);
      end
      if (i > 0) begin
        check("rr_imem_resp_val", 32'(imem_resp_val), (((i - 1) % 2) == 0) ? 32'd1 : 32'd0);
        check("rr_dmem_resp_val", 32'(dmem_resp_val), (((i - 1) % 2) == 1) ? 32'd1 : 32'd0);
      end
      tick();
    end
    be_resp_val = 1'b0;
    #1;
    check("rr_count_end", 32'(dut.count_q), 32'd0);

    // Fill to four outstanding; fifth blocked, no bypass on the popping cycle
    idle_all();
    do_reset();
    be_req_rdy = 1'b1; imem_req_val = 1'b1; imem_resp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_accept", 32'(imem_req_rdy), 32'd1);
      tick();
    end
    #1;
    check("full_block_rdy", 32'(imem_req_rdy), 32'd0);
    check("full_block_val", 32'(be_req_val), 32'd0);
    be_resp_val = 1'b1;
    #1;
    check("full_pop_rdy", 32'(be_resp_rdy), 32'd1);
    check("full_no_bypass", 32'(imem_req_rdy), 32'd0);
    tick();
    be_resp_val = 1'b0;
    #1;
    check("full_next_accept", 32'(imem_req_rdy), 32'd1);
    tick();
    imem_req_val = 1'b0;
    #1;
    check("full_count4", 32'(dut.count_q), 32'd4);
    be_resp_val = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    be_resp_val = 1'b0;
    #1;
    check("full_drained", 32'(dut.count_q), 32'd0);

    // Data response at head held by back-pressure, then delivered once
    idle_all();
    do_reset();
    be_req_rdy = 1'b1; dmem_req_val = 1'b1;
    tick();
    dmem_req_val = 1'b0;
    be_resp_val = 1'b1; be_resp_rdata = 32'hCAFE0001; imem_resp_rdy = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_be_resp_rdy", 32'(be_resp_rdy), 32'd0);
      check("hold_dmem_val", 32'(dmem_resp_val), 32'd1);
      check("hold_rdata", dmem_resp_rdata, 32'hCAFE0001);
      check("hold_imem_val", 32'(imem_resp_val), 32'd0);
      tick();
    end
    dmem_resp_rdy = 1'b1;
    #1;
    check("hold_release_rdy", 32'(be_resp_rdy), 32'd1);
    if (dmem_resp_val && dmem_resp_rdy) dcnt++;
    tick();
    be_resp_val = 1'b0;
    #1;
    if (dmem_resp_val && dmem_resp_rdy) dcnt++;
    check("hold_delivered_once", 32'(dcnt), 32'd1);
    check("hold_count", 32'(dut.count_q), 32'd0);

    // Six mixed transactions across the pointer wrap, push+pop at count 2
    idle_all();
    be_req_rdy = 1'b1; imem_resp_rdy = 1'b1; dmem_resp_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      imem_req_val = 1'b0;
      dmem_req_val = 1'b0;
      if (k < 6) begin
        if (seq[k] == 0) imem_req_val = 1'b1;
        else             dmem_req_val = 1'b1;
      end
      be_resp_val   = (k >= 2);
      be_resp_rdata = 32'h5000 + 32'(k);
      #1;
      if (k >= 2) begin
        check("wrap_imem_val", 32'(imem_resp_val), (seq[k-2] == 0) ? 32'd1 : 32'd0);
        check("wrap_dmem_val", 32'(dmem_resp_val), (seq[k-2] == 1) ? 32'd1 : 32'd0);
      end
      tick();
      if (k >= 2 && k < 6) check("wrap_count2", 32'(dut.count_q), 32'd2);
    end
    be_resp_val = 1'b0;
    #1;
    check("wrap_count0", 32'(dut.count_q), 32'd0);

    // Reset with three outstanding (priority left pointing at data)
    idle_all();
    be_req_rdy = 1'b1; imem_req_val = 1'b1;
    tick();
    tick();
    tick();
    imem_req_val = 1'b0;
    #1;
    check("mrst_count3", 32'(dut.count_q), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_resp_rdy = 1'b1; dmem_resp_rdy = 1'b1;
    imem_req_val = 1'b1; dmem_req_val = 1'b1;
    #1;
    check("mrst_count0", 32'(dut.count_q), 32'd0);
    check("mrst_be_resp_rdy", 32'(be_resp_rdy), 32'd0);
    check("mrst_pri_inst", be_req_addr, 32'h1000);
    check("mrst_imem_req_rdy", 32'(imem_req_rdy), 32'd1);
    idle_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
